score_event_ctrl: RTL and testbench

- Upstream stage of the score block: turns per-pixel collision overlaps into clean single-cycle score events.
- Overlaps are player drawing request AND gold/diamond drawing request during active video.
- Emits at most one `player_eat_gold` and one `player_eat_dimond` pulse per frame, serialized on distinct cycles.
- Applies a per-type re-trigger cooldown while the eaten object is removed from screen, and tracks the consecutive-diamond bonus streak.

---
 rtl/score_event_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_score_event_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_event_ctrl.sv
// ---------------------------------------------------------------------------
// score_event_ctrl
// Turns per-pixel player/gold and player/diamond overlaps into clean
// single-cycle score events, at most one of each type per frame, delivered
// on distinct cycles (gold first). A per-type cooldown blocks re-triggering
// while the eaten object is being removed, and a diamond streak counter
// raises combo_bonus after COMBO_LEN diamond events that are never more than
// COMBO_WINDOW frames apart.
//
// Ports
//   clk                system clock
//   reset              asynchronous, active-high reset
//   startOfFrame       one-cycle pulse at each frame start
//   game_active        collisions ignored when low
//   player_dr          player drawing request, current pixel
//   gold_dr            gold drawing request, current pixel
//   dimond_dr          diamond drawing request, current pixel
//   player_eat_gold    one-cycle gold event
//   player_eat_dimond  one-cycle diamond event
//   combo_bonus        one-cycle streak-complete pulse
//   combo_count        current diamond streak (0..COMBO_LEN-1)
//
// FSM states
//   state  | meaning
//   IDLE   | waiting for a pending event
//   EMIT_G | gold pulse on the outputs this cycle, pend_g being cleared
//   EMIT_D | diamond pulse on the outputs this cycle, streak being updated
//   EMIT_B | combo_bonus pulse on the outputs this cycle
// ---------------------------------------------------------------------------
module score_event_ctrl #(
   parameter int COOLDOWN_FRAMES = 2,
   parameter int COMBO_LEN       = 8,
   parameter int COMBO_WINDOW    = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       startOfFrame,
   input  logic       game_active,
   input  logic       player_dr,
   input  logic       gold_dr,
   input  logic       dimond_dr,
   output logic       player_eat_gold,
   output logic       player_eat_dimond,
   output logic       combo_bonus,
   output logic [3:0] combo_count
);

   localparam logic [3:0] COOL   = 4'(COOLDOWN_FRAMES);
   localparam logic [3:0] LEN_M1 = 4'(COMBO_LEN - 1);
   localparam logic [7:0] WIN    = 8'(COMBO_WINDOW);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EMIT_G = 2'd1,
      EMIT_D = 2'd2,
      EMIT_B = 2'd3
   } state_t;

   state_t     state;

   logic       hit_g;
   logic       hit_d;
   logic       pend_g;
   logic       pend_d;
   logic [3:0] cool_g;
   logic [3:0] cool_d;
   logic [7:0] win_cnt;

   logic       hit_now_g;
   logic       hit_now_d;
   logic       cap_g;
   logic       cap_d;
   logic       serve_g;
   logic       serve_d;
   logic       win_hit;

   assign hit_now_g = game_active & player_dr & gold_dr;
   assign hit_now_d = game_active & player_dr & dimond_dr;

   // Capture gating uses the cooldown value before this frame's decrement.
   assign cap_g = hit_g & (cool_g == 4'd0);
   assign cap_d = hit_d & (cool_d == 4'd0);

   assign serve_g = (state == EMIT_G);
   assign serve_d = (state == EMIT_D);

   // True when this empty frame brings the window counter to its limit.
   assign win_hit = ({1'b0, win_cnt} + 9'd1) >= {1'b0, WIN};

   // -----------------------------------------------------------------------
   // Hit latches, pending flags, cooldowns, streak window and combo count
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_g       <= 1'b0;
         hit_d       <= 1'b0;
         pend_g      <= 1'b0;
         pend_d      <= 1'b0;
         cool_g      <= 4'd0;
         cool_d      <= 4'd0;
         win_cnt     <= 8'd0;
         combo_count <= 4'd0;
      end else begin
         // A hit in the startOfFrame cycle belongs to the new frame.
         if (startOfFrame) begin
            hit_g <= hit_now_g;
            hit_d <= hit_now_d;
         end else begin
            hit_g <= hit_g | hit_now_g;
            hit_d <= hit_d | hit_now_d;
         end

         // A new capture wins over a same-cycle clear so nothing is lost.
         pend_g <= (pend_g & ~serve_g) | (startOfFrame & cap_g);
         pend_d <= (pend_d & ~serve_d) | (startOfFrame & cap_d);

         if (serve_g) begin
            cool_g <= COOL;
         end else if (startOfFrame && (cool_g != 4'd0)) begin
            cool_g <= cool_g - 4'd1;
         end

         if (serve_d) begin
            cool_d <= COOL;
         end else if (startOfFrame && (cool_d != 4'd0)) begin
            cool_d <= cool_d - 4'd1;
         end

         if (serve_d) begin
            win_cnt <= 8'd0;
            if (combo_count == LEN_M1) begin
               combo_count <= 4'd0;
            end else begin
               combo_count <= combo_count + 4'd1;
            end
         end else if (startOfFrame && !cap_d) begin
            // Counter holds once it reaches the window limit.
            if ((win_cnt != 8'hFF) && (win_cnt < WIN)) begin
               win_cnt <= win_cnt + 8'd1;
            end
            if (win_hit) begin
               combo_count <= 4'd0;
            end
         end
      end
   end

   // -----------------------------------------------------------------------
   // Event sequencer; each output is registered alongside the state it
   // belongs to, so the pulse is high exactly while the FSM sits in it.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         player_eat_gold   <= 1'b0;
         player_eat_dimond <= 1'b0;
         combo_bonus       <= 1'b0;
      end else begin
         player_eat_gold   <= 1'b0;
         player_eat_dimond <= 1'b0;
         combo_bonus       <= 1'b0;
         case (state)
            IDLE: begin
               if (pend_g) begin
                  state           <= EMIT_G;
                  player_eat_gold <= 1'b1;
               end else if (pend_d) begin
                  state             <= EMIT_D;
                  player_eat_dimond <= 1'b1;
               end
            end
            EMIT_G: begin
               if (pend_d) begin
                  state             <= EMIT_D;
                  player_eat_dimond <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            EMIT_D: begin
               if (combo_count == LEN_M1) begin
                  state       <= EMIT_B;
                  combo_bonus <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            EMIT_B: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_score_event_ctrl.sv
module tb_score_event_ctrl;

   localparam int COOL = 2;
   localparam int LEN  = 8;
   localparam int CW   = 60;
   localparam int FL   = 10;

   logic       clk;
   logic       reset;
   logic       startOfFrame;
   logic       game_active;
   logic       player_dr;
   logic       gold_dr;
   logic       dimond_dr;
   logic       player_eat_gold;
   logic       player_eat_dimond;
   logic       combo_bonus;
   logic [3:0] combo_count;

   int n_tests = 0;
   int n_fail  = 0;

   score_event_ctrl #(
      .COOLDOWN_FRAMES(COOL),
      .COMBO_LEN(LEN),
      .COMBO_WINDOW(CW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .startOfFrame(startOfFrame),
      .game_active(game_active),
      .player_dr(player_dr),
      .gold_dr(gold_dr),
      .dimond_dr(dimond_dr),
      .player_eat_gold(player_eat_gold),
      .player_eat_dimond(player_eat_dimond),
      .combo_bonus(combo_bonus),
      .combo_count(combo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ------------------------------------------------------------------------
   // Frame-level reference model. At each frame start it decides, from the
   // hits seen during the previous frame, which events fire and schedules the
   // cycles on which each pulse and each combo_count change must appear.
   // ------------------------------------------------------------------------
   int  cyc = 0;
   int  g_at, d_at, b_at, upd_at, upd_val;
   bit  mh_g, mh_d;
   int  mcg, mcd, mwin, mstreak, exp_cc;

   task automatic model_clear();
      g_at = -100; d_at = -100; b_at = -100; upd_at = -100; upd_val = 0;
      mh_g = 0; mh_d = 0; mcg = 0; mcd = 0; mwin = 0; mstreak = 0; exp_cc = 0;
   endtask

   initial model_clear();

   always @(posedge clk) begin
      bit hg, hd, gcap, dcap;
      int t;
      t   = cyc;
      cyc = cyc + 1;
      hg  = game_active & player_dr & gold_dr;
      hd  = game_active & player_dr & dimond_dr;
      if (reset) begin
         model_clear();
      end else if (startOfFrame) begin
         gcap = mh_g && (mcg == 0);
         dcap = mh_d && (mcd == 0);
         if (mcg > 0) mcg--;
         if (mcd > 0) mcd--;
         if (gcap) begin
            g_at = t + 2;
            mcg  = COOL;
         end
         if (!dcap) begin
            if (mwin < CW) mwin++;
            if (mwin == CW) begin
               mstreak = 0;
               upd_at  = t + 1;
               upd_val = 0;
            end
         end else begin
            d_at = gcap ? t + 3 : t + 2;
            mcd  = COOL;
            mwin = 0;
            if (mstreak == LEN - 1) begin
               b_at    = d_at + 1;
               mstreak = 0;
            end else begin
               mstreak++;
            end
            upd_at  = d_at + 1;
            upd_val = mstreak;
         end
         mh_g = hg;
         mh_d = hd;
      end else begin
         mh_g = mh_g | hg;
         mh_d = mh_d | hd;
      end
      #1;
      if (upd_at == cyc) exp_cc = upd_val;
      chk("model", {25'd0, player_eat_gold, player_eat_dimond, combo_bonus, combo_count},
          {25'd0, (g_at == cyc), (d_at == cyc), (b_at == cyc), 4'(exp_cc)});
   end

   // ------------------------------------------------------------------------
   // Frame driver: observes the outputs of every cycle (sampled on the
   // falling edge) and then drives the inputs for that cycle.
   // ------------------------------------------------------------------------
   logic [15:0] obs_g, obs_d, obs_b;
   logic [3:0]  obs_cc;

   task automatic run_frame(input bit ga, input bit p, input bit g, input bit d,
                            input int ov_from, input int ov_to, input int rst_at);
      bit ov;
      obs_g = '0; obs_d = '0; obs_b = '0;
      for (int k = 0; k < FL; k++) begin
         @(negedge clk);
         obs_g[k] = player_eat_gold;
         obs_d[k] = player_eat_dimond;
         obs_b[k] = combo_bonus;
         obs_cc   = combo_count;
         reset        = (rst_at >= 0) && (k >= rst_at);
         startOfFrame = (k == 0);
         game_active  = ga;
         ov           = (k >= ov_from) && (k <= ov_to);
         player_dr    = ov & p;
         gold_dr      = ov & g;
         dimond_dr    = ov & d;
      end
   endtask

   task automatic check_frame(input string nm, input bit eg, input bit ed, input bit eb,
                              input logic [3:0] ecc);
      logic [15:0] mg, md, mb;
      mg = eg ? 16'h0004 : 16'h0000;
      md = ed ? (16'h0001 << (eg ? 3 : 2)) : 16'h0000;
      mb = eb ? (16'h0001 << (eg ? 4 : 3)) : 16'h0000;
      chk({nm, "_gold"}, {16'd0, obs_g}, {16'd0, mg});
      chk({nm, "_dia"},  {16'd0, obs_d}, {16'd0, md});
      chk({nm, "_bonus"}, {16'd0, obs_b}, {16'd0, mb});
      chk({nm, "_cc"}, {28'd0, obs_cc}, {28'd0, ecc});
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; startOfFrame = 0; game_active = 0;
      player_dr = 0; gold_dr = 0; dimond_dr = 0;
      repeat (2) @(negedge clk);
      chk("reset_outs", {28'd0, player_eat_gold, player_eat_dimond, combo_bonus, |combo_count},
          32'd0);
   endtask

   typedef struct {
      bit         ga, p, g, d;
      bit         eg, ed, eb;
      logic [3:0] ecc;
      string      name;
   } vec_t;

   vec_t vecs[7];
   int   ng, nev;
   logic [3:0] ecc;

   initial begin
      // inputs overlap in cycles 4..6; expectations are the pulses at the
      // start of the same frame, caused by the previous frame's overlaps
      vecs[0] = '{1, 1, 1, 0, 0, 0, 0, 4'd0, "v_idle"};
      vecs[1] = '{1, 1, 1, 1, 1, 0, 0, 4'd0, "v_gold"};
      vecs[2] = '{0, 1, 1, 1, 0, 1, 0, 4'd1, "v_dia_gcool"};
      vecs[3] = '{1, 0, 1, 1, 0, 0, 0, 4'd1, "v_ga_low"};
      vecs[4] = '{1, 1, 1, 1, 0, 0, 0, 4'd1, "v_noplayer"};
      vecs[5] = '{1, 0, 0, 0, 1, 1, 0, 4'd2, "v_both"};
      vecs[6] = '{1, 0, 0, 0, 0, 0, 0, 4'd2, "v_quiet"};

      reset = 1'b1; startOfFrame = 0; game_active = 0;
      player_dr = 0; gold_dr = 0; dimond_dr = 0;
      repeat (3) @(negedge clk);
      chk("reset_init", {28'd0, player_eat_gold, player_eat_dimond, combo_bonus, |combo_count},
          32'd0);

      for (int i = 0; i < 7; i++) begin
         run_frame(vecs[i].ga, vecs[i].p, vecs[i].g, vecs[i].d, 4, 6, -1);
         check_frame(vecs[i].name, vecs[i].eg, vecs[i].ed, vecs[i].eb, vecs[i].ecc);
      end

      // gold held continuously for 5 frames: pulses at boundaries 1 and 4
      do_reset();
      ng = 0;
      for (int f = 0; f < 7; f++) begin
         run_frame(1, 1, 1, 0, 0, (f < 5) ? FL - 1 : -1, -1);
         check_frame($sformatf("hold_f%0d", f), (f == 1) || (f == 4), 0, 0, 4'd0);
         ng += $countones(obs_g);
      end
      chk("hold_total", ng, 2);

      // eight diamond events spaced to clear the cooldown -> combo_bonus
      do_reset();
      nev = 0;
      ecc = 4'd0;
      for (int f = 0; f < 25; f++) begin
         bit ev;
         ev = (f % 3 == 1) && (f <= 22);
         if (ev) begin
            nev++;
            ecc = 4'(nev % LEN);
         end
         run_frame(1, 1, 0, 1, 4, ((f % 3 == 0) && (f <= 21)) ? 6 : -1, -1);
         check_frame($sformatf("combo_f%0d", f), 0, ev, ev && (nev == LEN), ecc);
      end

      // streak cleared after COMBO_WINDOW empty frame boundaries
      do_reset();
      for (int f = 0; f < 69; f++) begin
         bit dv;
         dv = (f == 0) || (f == 3) || (f == 6) || (f == 67);
         run_frame(1, 1, 0, 1, 4, dv ? 6 : -1, -1);
         if (f == 7)  check_frame("win_f7", 0, 1, 0, 4'd3);
         if (f == 66) check_frame("win_f66", 0, 0, 0, 4'd3);
         if (f == 67) check_frame("win_f67", 0, 0, 0, 4'd0);
         if (f == 68) check_frame("win_f68", 0, 1, 0, 4'd1);
      end

      // reset in the cycle after startOfFrame with both events pending
      do_reset();
      run_frame(1, 1, 1, 1, 4, 6, -1);
      run_frame(1, 0, 0, 0, 0, -1, 1);
      check_frame("rst_mid_f1", 0, 0, 0, 4'd0);
      run_frame(1, 0, 0, 0, 0, -1, -1);
      check_frame("rst_mid_f2", 0, 0, 0, 4'd0);
      run_frame(1, 0, 0, 0, 0, -1, -1);
      check_frame("rst_mid_f3", 0, 0, 0, 4'd0);

      // random overlaps, including on startOfFrame cycles, against the model
      do_reset();
      for (int f = 0; f < 250; f++) begin
         int len;
         len = 8 + int'($urandom_range(0, 8));
         for (int k = 0; k < len; k++) begin
            @(negedge clk);
            reset        = 1'b0;
            startOfFrame = (k == 0);
            game_active  = ($urandom_range(0, 7) != 0);
            player_dr    = ($urandom_range(0, 1) != 0);
            gold_dr      = ($urandom_range(0, 5) == 0);
            dimond_dr    = ($urandom_range(0, 3) == 0);
         end
      end
      @(negedge clk);
      startOfFrame = 0; player_dr = 0;
      repeat (6) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
